// File: rtl/gnss_signal_gen.sv
// GPS L1 C/A-style signal generator: code NCO driving G1/G2 Gold-code LFSRs,
// chip/epoch/nav-bit counters, a one-entry navigation-bit buffer with a
// valid/ready handshake, and a carrier NCO quantised to a 2-bit sign/magnitude
// IF sample. All outputs are registered with one cycle of latency.
module gnss_signal_gen (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] code_fcw,
    input  logic [31:0] carr_fcw,
    input  logic [3:0]  g2_tap_a,
    input  logic [3:0]  g2_tap_b,
    input  logic        nav_bit,
    input  logic        nav_valid,
    output logic        nav_ready,
    output logic        sample_sign,
    output logic        sample_mag,
    output logic        sample_valid,
    output logic        epoch,
    output logic        nav_edge,
    output logic        nav_underrun
);

    localparam logic [9:0] LFSR_SEED    = 10'h3FF;
    localparam logic [9:0] LAST_CHIP    = 10'd1022;
    localparam logic [4:0] LAST_EPOCH   = 5'd19;

    // Bit i-1 of the LFSR vector holds stage i, so stage 10 is bit 9.
    function automatic logic g2Select(input logic [9:0] g2, input logic [3:0] tap);
        logic bitSel;
        bitSel = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (tap == 4'(i)) begin
                bitSel = g2[i-1];
            end
        end
        return bitSel;
    endfunction

    logic [31:0] codeAcc_q,     codeAcc_d;
    logic [31:0] carrAcc_q,     carrAcc_d;
    logic [9:0]  g1_q,          g1_d;
    logic [9:0]  g2_q,          g2_d;
    logic [9:0]  chipCnt_q,     chipCnt_d;
    logic [4:0]  epochCnt_q,    epochCnt_d;
    logic        curNav_q,      curNav_d;
    logic        bufBit_q,      bufBit_d;
    logic        bufFull_q,     bufFull_d;
    logic        underrun_q,    underrun_d;
    logic        sampleSign_q,  sampleSign_d;
    logic        sampleMag_q,   sampleMag_d;
    logic        sampleValid_q, sampleValid_d;
    logic        epoch_q,       epoch_d;
    logic        navEdge_q,     navEdge_d;

    logic [32:0] codeSum;
    logic        chipTick;
    logic        chipBit;
    logic        carNeg;
    logic        carBig;
    logic        epochEvt;
    logic        edgeEvt;
    logic        navAccept;

    // Next-state logic: NCOs, LFSRs, counters, nav buffer and the output sample,
    // all derived from the current (pre-update) register state.
    always_comb begin
        codeAcc_d     = codeAcc_q;
        carrAcc_d     = carrAcc_q;
        g1_d          = g1_q;
        g2_d          = g2_q;
        chipCnt_d     = chipCnt_q;
        epochCnt_d    = epochCnt_q;
        curNav_d      = curNav_q;
        bufBit_d      = bufBit_q;
        bufFull_d     = bufFull_q;
        underrun_d    = underrun_q;
        sampleSign_d  = sampleSign_q;
        sampleMag_d   = sampleMag_q;
        sampleValid_d = 1'b0;
        epoch_d       = 1'b0;
        navEdge_d     = 1'b0;

        codeSum   = {1'b0, codeAcc_q} + {1'b0, code_fcw};
        chipTick  = codeSum[32];
        chipBit   = g1_q[9] ^ g2Select(g2_q, g2_tap_a) ^ g2Select(g2_q, g2_tap_b);
        carNeg    = carrAcc_q[31] ^ carrAcc_q[30];
        carBig    = ~(carrAcc_q[30] ^ carrAcc_q[29]);
        epochEvt  = enable && chipTick && (chipCnt_q == LAST_CHIP);
        edgeEvt   = epochEvt && (epochCnt_q == LAST_EPOCH);
        navAccept = nav_valid && !bufFull_q;

        if (enable) begin
            codeAcc_d     = codeSum[31:0];
            carrAcc_d     = carrAcc_q + carr_fcw;
            sampleSign_d  = chipBit ^ curNav_q ^ carNeg;
            sampleMag_d   = carBig;
            sampleValid_d = 1'b1;
            epoch_d       = epochEvt;
            navEdge_d     = edgeEvt;

            if (chipTick) begin
                if (chipCnt_q == LAST_CHIP) begin
                    chipCnt_d  = 10'd0;
                    g1_d       = LFSR_SEED;
                    g2_d       = LFSR_SEED;
                    epochCnt_d = (epochCnt_q == LAST_EPOCH) ? 5'd0 : epochCnt_q + 5'd1;
                end else begin
                    chipCnt_d = chipCnt_q + 10'd1;
                    g1_d      = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
                    g2_d      = {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5] ^
                                            g2_q[7] ^ g2_q[8] ^ g2_q[9]};
                end
            end

            if (edgeEvt) begin
                if (bufFull_q) begin
                    curNav_d  = bufBit_q;
                    bufFull_d = 1'b0;
                end else begin
                    curNav_d   = 1'b0;
                    underrun_d = 1'b1;
                end
            end
        end

        // The handshake runs even while the generator is paused; an accept
        // only happens into an empty buffer, so it never collides with a drain.
        if (navAccept) begin
            bufFull_d = 1'b1;
            bufBit_d  = nav_bit;
        end
    end

    // State register with synchronous reset back to the code-phase origin.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            codeAcc_q     <= 32'd0;
            carrAcc_q     <= 32'd0;
            g1_q          <= LFSR_SEED;
            g2_q          <= LFSR_SEED;
            chipCnt_q     <= 10'd0;
            epochCnt_q    <= 5'd0;
            curNav_q      <= 1'b0;
            bufBit_q      <= 1'b0;
            bufFull_q     <= 1'b0;
            underrun_q    <= 1'b0;
            sampleSign_q  <= 1'b0;
            sampleMag_q   <= 1'b0;
            sampleValid_q <= 1'b0;
            epoch_q       <= 1'b0;
            navEdge_q     <= 1'b0;
        end else begin
            codeAcc_q     <= codeAcc_d;
            carrAcc_q     <= carrAcc_d;
            g1_q          <= g1_d;
            g2_q          <= g2_d;
            chipCnt_q     <= chipCnt_d;
            epochCnt_q    <= epochCnt_d;
            curNav_q      <= curNav_d;
            bufBit_q      <= bufBit_d;
            bufFull_q     <= bufFull_d;
            underrun_q    <= underrun_d;
            sampleSign_q  <= sampleSign_d;
            sampleMag_q   <= sampleMag_d;
            sampleValid_q <= sampleValid_d;
            epoch_q       <= epoch_d;
            navEdge_q     <= navEdge_d;
        end
    end

    assign nav_ready    = !bufFull_q;
    assign sample_sign  = sampleSign_q;
    assign sample_mag   = sampleMag_q;
    assign sample_valid = sampleValid_q;
    assign epoch        = epoch_q;
    assign nav_edge     = navEdge_q;
    assign nav_underrun = underrun_q;

endmodule

// File: tb/tb_gnss_signal_gen.sv
// Bench for gnss_signal_gen: stimulus pushes the expected sample for every
// enabled cycle into a queue, and a monitor pops and compares whenever the
// DUT presents sample_valid.
module tb_gnss_signal_gen;

    logic        sys_clk;
    logic        rst;
    logic        enable;
    logic [31:0] code_fcw;
    logic [31:0] carr_fcw;
    logic [3:0]  g2_tap_a;
    logic [3:0]  g2_tap_b;
    logic        nav_bit;
    logic        nav_valid;
    logic        nav_ready;
    logic        sample_sign;
    logic        sample_mag;
    logic        sample_valid;
    logic        epoch;
    logic        nav_edge;
    logic        nav_underrun;

    typedef struct {
        logic chkSign;
        logic expSign;
        logic chkMag;
        logic expMag;
        logic expEpoch;
        logic expEdge;
        int   idx;
    } Expectation;

    Expectation expQ[$];
    Expectation monEntry;

    int total;
    int bad;

    // PRN 1 (taps 2/6) first ten chips, octal 1440, first chip in the MSB.
    logic [9:0] prnBits;
    // Carrier pattern for carr_fcw=2^29 with baseband chip^nav = 1.
    logic [7:0] carrSign;
    logic [7:0] carrMag;

    gnss_signal_gen dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .enable       (enable),
        .code_fcw     (code_fcw),
        .carr_fcw     (carr_fcw),
        .g2_tap_a     (g2_tap_a),
        .g2_tap_b     (g2_tap_b),
        .nav_bit      (nav_bit),
        .nav_valid    (nav_valid),
        .nav_ready    (nav_ready),
        .sample_sign  (sample_sign),
        .sample_mag   (sample_mag),
        .sample_valid (sample_valid),
        .epoch        (epoch),
        .nav_edge     (nav_edge),
        .nav_underrun (nav_underrun)
    );

    // Free-running 100 MHz clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Hard stop in case the sequence never reaches its summary.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic nv, input logic nb);
        enable    = en;
        nav_valid = nv;
        nav_bit   = nb;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pushExpect(input logic cs, input logic es, input logic cm, input logic em,
                              input logic ep, input logic ed, input int idx);
        Expectation e;
        e.chkSign  = cs;
        e.expSign  = es;
        e.chkMag   = cm;
        e.expMag   = em;
        e.expEpoch = ep;
        e.expEdge  = ed;
        e.idx      = idx;
        expQ.push_back(e);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Monitor: compare each presented sample against the oldest expectation.
    always @(negedge sys_clk) begin
        if (sample_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_sample: got sample_valid=1 want no sample");
            end else begin
                monEntry = expQ.pop_front();
                if (monEntry.chkSign)
                    checkOutput($sformatf("sign[%0d]", monEntry.idx), sample_sign, monEntry.expSign);
                if (monEntry.chkMag)
                    checkOutput($sformatf("mag[%0d]", monEntry.idx), sample_mag, monEntry.expMag);
                checkOutput($sformatf("epoch[%0d]", monEntry.idx), epoch, monEntry.expEpoch);
                checkOutput($sformatf("nav_edge[%0d]", monEntry.idx), nav_edge, monEntry.expEdge);
            end
        end
    end

    // Directed sequence: PRN/epoch/underrun run, carrier pattern, freeze and
    // mid-run reset, then a buffered nav=1 run with a fast code NCO.
    initial begin
        int   p;
        logic cs;
        logic es;
        logic nav;

        total     = 0;
        bad       = 0;
        prnBits   = 10'b1100100000;
        carrSign  = 8'b11000011;
        carrMag   = 8'b10011001;
        rst       = 1'b1;
        enable    = 1'b0;
        nav_valid = 1'b0;
        nav_bit   = 1'b0;
        code_fcw  = 32'h8000_0000;
        carr_fcw  = 32'd0;
        g2_tap_a  = 4'd2;
        g2_tap_b  = 4'd6;

        // Long run at half-rate chips: PRN windows, epoch/nav_edge timing, underrun.
        doReset();
        checkOutput("reset_valid", sample_valid, 1'b0);
        checkOutput("reset_ready", nav_ready, 1'b1);
        for (int n = 0; n < 40960; n++) begin
            p  = n % 2046;
            cs = (p < 20);
            es = cs ? prnBits[9 - p / 2] : 1'b0;
            pushExpect(cs, es, 1'b1, 1'b1, ((n + 1) % 2046) == 0, n == 40919, n);
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (n == 40000)
                checkOutput("underrun_before_edge", nav_underrun, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("underrun_after_edge", nav_underrun, 1'b1);
        checkOutput("ready_before_accept", nav_ready, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("ready_after_accept", nav_ready, 1'b0);
        checkOutput("underrun_sticky", nav_underrun, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Carrier-only run: 8-cycle sign/magnitude pattern on a constant chip of 1.
        code_fcw = 32'd0;
        carr_fcw = 32'h2000_0000;
        doReset();
        checkOutput("underrun_cleared", nav_underrun, 1'b0);
        checkOutput("ready_after_reset", nav_ready, 1'b1);
        for (int i = 0; i < 16; i++) begin
            pushExpect(1'b1, carrSign[7 - (i % 8)], 1'b1, carrMag[7 - (i % 8)], 1'b0, 1'b0, i);
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Freeze mid-chip, resume, then reset mid-run with a nav bit buffered.
        code_fcw = 32'h8000_0000;
        carr_fcw = 32'd0;
        doReset();
        for (int n = 0; n < 3; n++) begin
            pushExpect(1'b1, prnBits[9 - n / 2], 1'b1, 1'b1, 1'b0, 1'b0, n);
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("frozen_valid[%0d]", i), sample_valid, 1'b0);
            checkOutput($sformatf("frozen_sign[%0d]", i), sample_sign, 1'b1);
            checkOutput($sformatf("frozen_mag[%0d]", i), sample_mag, 1'b1);
        end
        for (int n = 3; n < 12; n++) begin
            pushExpect(1'b1, prnBits[9 - n / 2], 1'b1, 1'b1, 1'b0, 1'b0, n);
            applyStimulus(1'b1, n == 10, 1'b1);
        end
        checkOutput("ready_buffered", nav_ready, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("midrun_reset_valid", sample_valid, 1'b0);
        checkOutput("midrun_reset_sign", sample_sign, 1'b0);
        checkOutput("midrun_reset_mag", sample_mag, 1'b0);
        checkOutput("midrun_reset_epoch", epoch, 1'b0);
        checkOutput("midrun_reset_edge", nav_edge, 1'b0);
        checkOutput("midrun_reset_underrun", nav_underrun, 1'b0);
        checkOutput("midrun_reset_ready", nav_ready, 1'b1);
        for (int n = 0; n < 20; n++) begin
            pushExpect(1'b1, prnBits[9 - n / 2], 1'b1, 1'b1, 1'b0, 1'b0, n);
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Fast code NCO (a chip per cycle after the first) with nav=1 buffered.
        code_fcw = 32'hFFFF_FFFF;
        doReset();
        for (int n = 0; n < 23540; n++) begin
            nav = (n > 20460);
            if (n == 0) begin
                cs = 1'b1;
                es = 1'b1;
            end else begin
                p  = (n - 1) % 1023;
                cs = (p < 10);
                es = cs ? (prnBits[9 - p] ^ nav) : 1'b0;
            end
            pushExpect(cs, es, 1'b1, 1'b1, (n > 0) && ((n % 1023) == 0), n == 20460, n);
            applyStimulus(1'b1, n == 0, n == 0);
            if (n == 20000)
                checkOutput("ready_full_before_edge", nav_ready, 1'b0);
            if (n == 20459)
                checkOutput("ready_held_until_edge", nav_ready, 1'b0);
            if (n == 20460) begin
                checkOutput("ready_after_edge", nav_ready, 1'b1);
                checkOutput("no_underrun_with_data", nav_underrun, 1'b0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL queue_drained: got %0d pending samples want 0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
